res_station: RTL and testbench

Tomasulo reservation station for the ALU. It accepts issued instructions with operand values or ROB tags from the ROB and register file. It snoops the CDB to capture pending operands and dispatches the oldest ready entry to the ALU as an `alu_word`. It consumes the ROB-side operand protocol (`load_word`, `src1/src2`, `rob_tag1/2`, `rob_v1/2`) and drives the ALU-side signals (`alu_data`, `start_exe`, `res_empty`).

---
 rtl/tomasula_types.sv | 53 +++++
 rtl/res_station_entry.sv | 57 +++++
 rtl/res_station.sv | 131 +++++++++++++
 tb/tb_res_station.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tomasula_types.sv
`default_nettype none
// ============================================================================
// Package     : tomasula_types
// Description : Shared types for the Tomasulo ALU reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
package tomasula_types;

    localparam int ROB_TAG_W = 3;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLL = 3'd5,
        ALU_SRL = 3'd6,
        ALU_SLT = 3'd7
    } alu_ops;

    typedef struct packed {
        alu_ops                 op;
        logic [ROB_TAG_W-1:0]   dtag;
    } ctl_word;

    typedef struct packed {
        logic                   valid;
        logic [ROB_TAG_W-1:0]   tag;
        logic [31:0]            value;
    } cdb_data;

    typedef struct packed {
        alu_ops                 op;
        logic [31:0]            src1;
        logic [31:0]            src2;
        logic [ROB_TAG_W-1:0]   tag;
    } alu_word;

    typedef struct packed {
        logic                   v;
        alu_ops                 op;
        logic [ROB_TAG_W-1:0]   dtag;
        logic                   rdy1;
        logic [ROB_TAG_W-1:0]   tag1;
        logic [31:0]            val1;
        logic                   rdy2;
        logic [ROB_TAG_W-1:0]   tag2;
        logic [31:0]            val2;
    } rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/res_station_entry.sv
`default_nettype none
// ============================================================================
// Module      : rs_entry
// Description : One reservation-station slot: shift-in mux plus CDB capture.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_entry
    import tomasula_types::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      sel_upper,
    input  logic      sel_new,
    input  rs_entry_t upper,
    input  rs_entry_t new_ent,
    input  cdb_data   cdb,
    output rs_entry_t ent
);

    rs_entry_t r_ent;
    rs_entry_t w_src;
    rs_entry_t w_next;

    // Capture is applied after the mux so shifted and freshly loaded
    // operands wake on the same broadcast as resident ones.
    always_comb begin
        w_src = r_ent;
        if (sel_new) begin
            w_src = new_ent;
        end else if (sel_upper) begin
            w_src = upper;
        end
        w_next = w_src;
        if (cdb.valid && w_src.v) begin
            if (!w_src.rdy1 && (w_src.tag1 == cdb.tag)) begin
                w_next.rdy1 = 1'b1;
                w_next.val1 = cdb.value;
            end
            if (!w_src.rdy2 && (w_src.tag2 == cdb.tag)) begin
                w_next.rdy2 = 1'b1;
                w_next.val2 = cdb.value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ent <= '0;
        end else begin
            r_ent <= w_next;
        end
    end

    assign ent = r_ent;

endmodule
`default_nettype wire

// File: rtl/res_station.sv
`default_nettype none
// ============================================================================
// Module      : res_station
// Description : Collapsing-queue ALU reservation station, oldest-ready issue.
// Revision    : 1.0 - initial release
// ============================================================================
module res_station
    import tomasula_types::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = ROB_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_word,
    input  ctl_word          control_word,
    input  logic [31:0]      src1,
    input  logic [31:0]      src2,
    input  logic             rob_v1,
    input  logic             rob_v2,
    input  logic [TAG_W-1:0] rob_tag1,
    input  logic [TAG_W-1:0] rob_tag2,
    input  cdb_data          cdb,
    input  logic             alu_free,
    output alu_word          alu_data,
    output logic             start_exe,
    output logic             res_empty,
    output logic             res_full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rs_entry_t          w_ent   [DEPTH];
    rs_entry_t          w_upper [DEPTH];
    rs_entry_t          w_new;
    logic [DEPTH-1:0]   w_valid;
    logic [DEPTH-1:0]   w_sel_upper;
    logic [DEPTH-1:0]   w_sel_new;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_tail;
    logic [IDX_W-1:0]   w_disp_idx;
    logic               w_found;
    logic               w_do_disp;
    logic               w_do_load;
    alu_word            r_alu_data;
    logic               r_start_exe;

    always_comb begin
        w_new      = '0;
        w_new.v    = 1'b1;
        w_new.op   = control_word.op;
        w_new.dtag = control_word.dtag;
        w_new.rdy1 = rob_v1;
        w_new.tag1 = rob_tag1;
        w_new.val1 = rob_v1 ? src1 : 32'd0;
        w_new.rdy2 = rob_v2;
        w_new.tag2 = rob_tag2;
        w_new.val2 = rob_v2 ? src2 : 32'd0;
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            if (i == DEPTH - 1) begin : g_top
                assign w_upper[i] = '0;
            end else begin : g_mid
                assign w_upper[i] = w_ent[i+1];
            end

            rs_entry u_entry (
                .clk       (clk),
                .rst       (rst),
                .sel_upper (w_sel_upper[i]),
                .sel_new   (w_sel_new[i]),
                .upper     (w_upper[i]),
                .new_ent   (w_new),
                .cdb       (cdb),
                .ent       (w_ent[i])
            );

            assign w_valid[i] = w_ent[i].v;
        end
    endgenerate

    assign res_full  = &w_valid;
    assign res_empty = ~|w_valid;

    // Valid entries are contiguous, so the count is also the free-slot index;
    // a dispatch pulls that index down by one before the new entry lands.
    always_comb begin
        w_count    = '0;
        w_found    = 1'b0;
        w_disp_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + CNT_W'(w_valid[i]);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ent[i].v && w_ent[i].rdy1 && w_ent[i].rdy2) begin
                w_found    = 1'b1;
                w_disp_idx = IDX_W'(i);
            end
        end
        w_do_disp = w_found & alu_free;
        w_do_load = load_word & ~res_full;
        w_tail    = w_count - CNT_W'(w_do_disp);
        for (int i = 0; i < DEPTH; i++) begin
            w_sel_upper[i] = w_do_disp && (i >= int'(w_disp_idx));
            w_sel_new[i]   = w_do_load && (i == int'(w_tail));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_exe <= 1'b0;
            r_alu_data  <= '0;
        end else begin
            r_start_exe <= w_do_disp;
            if (w_do_disp) begin
                r_alu_data.op   <= w_ent[w_disp_idx].op;
                r_alu_data.src1 <= w_ent[w_disp_idx].val1;
                r_alu_data.src2 <= w_ent[w_disp_idx].val2;
                r_alu_data.tag  <= w_ent[w_disp_idx].dtag;
            end
        end
    end

    assign alu_data  = r_alu_data;
    assign start_exe = r_start_exe;

endmodule
`default_nettype wire

// File: tb/tb_res_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_res_station
// Description : Directed, table-driven self-checking bench for res_station.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_res_station;
    import tomasula_types::*;

    typedef struct {
        logic        load;
        alu_ops      op;
        logic [2:0]  dtag;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        v1;
        logic        v2;
        logic [2:0]  t1;
        logic [2:0]  t2;
        logic        cv;
        logic [2:0]  ct;
        logic [31:0] cval;
        logic        free;
        logic        e_start;
        alu_word     e_data;
        logic        e_empty;
        logic        e_full;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_word;
    ctl_word     control_word;
    logic [31:0] src1, src2;
    logic        rob_v1, rob_v2;
    logic [2:0]  rob_tag1, rob_tag2;
    cdb_data     cdb;
    logic        alu_free;
    alu_word     alu_data;
    logic        start_exe, res_empty, res_full;

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    res_station #(.DEPTH(4), .TAG_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_word    (load_word),
        .control_word (control_word),
        .src1         (src1),
        .src2         (src2),
        .rob_v1       (rob_v1),
        .rob_v2       (rob_v2),
        .rob_tag1     (rob_tag1),
        .rob_tag2     (rob_tag2),
        .cdb          (cdb),
        .alu_free     (alu_free),
        .alu_data     (alu_data),
        .start_exe    (start_exe),
        .res_empty    (res_empty),
        .res_full     (res_full)
    );

    function automatic vec_t idle(logic free, logic cv = 1'b0,
                                  logic [2:0] ct = 3'd0, logic [31:0] cval = 32'd0);
        vec_t r;
        r.load = 1'b0; r.op = ALU_ADD; r.dtag = 3'd0;
        r.s1 = 32'd0; r.s2 = 32'd0; r.v1 = 1'b1; r.v2 = 1'b1;
        r.t1 = 3'd0; r.t2 = 3'd0;
        r.cv = cv; r.ct = ct; r.cval = cval; r.free = free;
        r.e_start = 1'b0; r.e_data = '0; r.e_empty = 1'b1; r.e_full = 1'b0;
        return r;
    endfunction

    function automatic vec_t ld(alu_ops op, int dtag, int s1, int s2,
                                logic v1, logic v2, int t1, int t2, logic free);
        vec_t r;
        r = idle(free);
        r.load = 1'b1; r.op = op; r.dtag = dtag[2:0];
        r.s1 = s1; r.s2 = s2; r.v1 = v1; r.v2 = v2;
        r.t1 = t1[2:0]; r.t2 = t2[2:0];
        return r;
    endfunction

    function automatic vec_t ex(vec_t r, logic st, alu_word d, logic emp, logic full);
        vec_t o;
        o = r;
        o.e_start = st; o.e_data = d; o.e_empty = emp; o.e_full = full;
        return o;
    endfunction

    function automatic vec_t with_cdb(vec_t r, int ct, int cval);
        vec_t o;
        o = r;
        o.cv = 1'b1; o.ct = ct[2:0]; o.cval = cval;
        return o;
    endfunction

    task automatic check(string name, int row, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h exp=%0h", name, row, got, exp);
        end
    endtask

    task automatic drive(vec_t r);
        load_word    = r.load;
        control_word = '{op: r.op, dtag: r.dtag};
        src1 = r.s1; src2 = r.s2;
        rob_v1 = r.v1; rob_v2 = r.v2;
        rob_tag1 = r.t1; rob_tag2 = r.t2;
        cdb = '{valid: r.cv, tag: r.ct, value: r.cval};
        alu_free = r.free;
    endtask

    task automatic run_row(vec_t r, int row);
        @(negedge clk);
        drive(r);
        @(posedge clk);
        #1;
        check("start_exe", row, 128'(start_exe), 128'(r.e_start));
        if (r.e_start) check("alu_data", row, 128'(alu_data), 128'(r.e_data));
        check("res_empty", row, 128'(res_empty), 128'(r.e_empty));
        check("res_full", row, 128'(res_full), 128'(r.e_full));
    endtask

    initial begin
        rst = 1'b1;
        drive(idle(1'b1));

        // Basic ready-ready dispatch.
        tbl.push_back(ex(ld(ALU_ADD, 2, 5, 7, 1, 1, 0, 0, 1), 0, '0, 0, 0));
        tbl.push_back(ex(idle(1), 1, '{ALU_ADD, 32'd5, 32'd7, 3'd2}, 1, 0));
        tbl.push_back(ex(idle(1), 0, '0, 1, 0));
        // Wait on tag 4 for three cycles, then CDB wake.
        tbl.push_back(ex(ld(ALU_SUB, 1, 32'h99, 3, 0, 1, 4, 0, 1), 0, '0, 0, 0));
        tbl.push_back(ex(idle(1), 0, '0, 0, 0));
        tbl.push_back(ex(idle(1), 0, '0, 0, 0));
        tbl.push_back(ex(idle(1), 0, '0, 0, 0));
        tbl.push_back(ex(idle(1, 1, 3'd4, 32'h10), 0, '0, 0, 0));
        tbl.push_back(ex(idle(1), 1, '{ALU_SUB, 32'h10, 32'd3, 3'd1}, 1, 0));
        // Fill, drop the fifth load, then drain in order.
        tbl.push_back(ex(ld(ALU_AND, 0, 1, 2, 1, 1, 0, 0, 0), 0, '0, 0, 0));
        tbl.push_back(ex(ld(ALU_OR,  1, 3, 4, 1, 1, 0, 0, 0), 0, '0, 0, 0));
        tbl.push_back(ex(ld(ALU_XOR, 2, 5, 6, 1, 1, 0, 0, 0), 0, '0, 0, 0));
        tbl.push_back(ex(ld(ALU_ADD, 3, 7, 8, 1, 1, 0, 0, 0), 0, '0, 0, 1));
        tbl.push_back(ex(ld(ALU_SUB, 4, 9, 9, 1, 1, 0, 0, 0), 0, '0, 0, 1));
        tbl.push_back(ex(idle(1), 1, '{ALU_AND, 32'd1, 32'd2, 3'd0}, 0, 0));
        tbl.push_back(ex(idle(1), 1, '{ALU_OR,  32'd3, 32'd4, 3'd1}, 0, 0));
        tbl.push_back(ex(idle(1), 1, '{ALU_XOR, 32'd5, 32'd6, 3'd2}, 0, 0));
        tbl.push_back(ex(idle(1), 1, '{ALU_ADD, 32'd7, 32'd8, 3'd3}, 1, 0));
        tbl.push_back(ex(idle(1), 0, '0, 1, 0));
        // Younger ready entry bypasses older waiting one.
        tbl.push_back(ex(ld(ALU_ADD, 5, 0, 1, 0, 1, 6, 0, 0), 0, '0, 0, 0));
        tbl.push_back(ex(ld(ALU_SUB, 6, 20, 5, 1, 1, 0, 0, 0), 0, '0, 0, 0));
        tbl.push_back(ex(idle(1), 1, '{ALU_SUB, 32'd20, 32'd5, 3'd6}, 0, 0));
        tbl.push_back(ex(idle(1, 1, 3'd6, 32'h55), 0, '0, 0, 0));
        tbl.push_back(ex(idle(1), 1, '{ALU_ADD, 32'h55, 32'd1, 3'd5}, 1, 0));
        // Same-cycle CDB forward on load.
        tbl.push_back(ex(with_cdb(ld(ALU_XOR, 7, 2, 0, 1, 0, 0, 3, 1), 3, 32'hAB), 0, '0, 0, 0));
        tbl.push_back(ex(idle(1), 1, '{ALU_XOR, 32'd2, 32'hAB, 3'd7}, 1, 0));
        // Load + dispatch + CDB capture into a shifting entry, all one edge.
        tbl.push_back(ex(ld(ALU_ADD, 1, 1, 1, 1, 1, 0, 0, 0), 0, '0, 0, 0));
        tbl.push_back(ex(ld(ALU_OR,  2, 0, 2, 0, 1, 5, 0, 0), 0, '0, 0, 0));
        tbl.push_back(ex(with_cdb(ld(ALU_AND, 3, 4, 4, 1, 1, 0, 0, 1), 5, 32'h7),
                         1, '{ALU_ADD, 32'd1, 32'd1, 3'd1}, 0, 0));
        tbl.push_back(ex(idle(1), 1, '{ALU_OR,  32'h7, 32'd2, 3'd2}, 0, 0));
        tbl.push_back(ex(idle(1), 1, '{ALU_AND, 32'd4, 32'd4, 3'd3}, 1, 0));

        // Power-on reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", -1, 128'(start_exe), 128'(1'b0));
        check("rst_empty", -1, 128'(res_empty), 128'(1'b1));
        check("rst_full",  -1, 128'(res_full),  128'(1'b0));
        check("rst_data",  -1, 128'(alu_data),  128'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            run_row(tbl[i], i);
        end

        // Mid-operation reset discards three ready entries.
        run_row(ex(ld(ALU_ADD, 1, 11, 12, 1, 1, 0, 0, 0), 0, '0, 0, 0), 100);
        run_row(ex(ld(ALU_SUB, 2, 13, 14, 1, 1, 0, 0, 0), 0, '0, 0, 0), 101);
        run_row(ex(ld(ALU_OR,  3, 15, 16, 1, 1, 0, 0, 0), 0, '0, 0, 0), 102);
        @(negedge clk);
        drive(idle(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_start", 103, 128'(start_exe), 128'(1'b0));
        check("mid_rst_empty", 103, 128'(res_empty), 128'(1'b1));
        check("mid_rst_data",  103, 128'(alu_data),  128'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_row(idle(1), 104 + i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
